dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the five-stage pipeline. The MEM stage is the initiator: it issues one load or store request over a valid/ready handshake. This block is the far end of that interface. It owns the data-memory array, models a fixed access latency, and applies RISC-V byte/halfword/word sizing, little-endian lane selection, load sign/zero extension and alignment checking. It returns a response over a second valid/ready handshake, and the MEM stage stalls while `req_ready` or `rsp_valid` is pending.

## Interface
- `DATA_W`, 32: data width; fixed at 32 (RV32).
- `DM_ADDRESS`, 9: byte-address width; the array holds 2^(DM_ADDRESS-2) words.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the load/store.
- `req_addr`  in  DM_ADDRESS  byte address.
- `req_wdata`  in  DATA_W  store data; the low bytes are used for SB/SH.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator takes the response.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `rsp_error`  out  1  misaligned access or illegal funct3.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready` = 1 only when in IDLE and `reset` = 1.
  - On an edge with `req_valid & req_ready`:
    - latch write, funct3, addr and wdata;
    - load counter with LATENCY-1;
    - go to WAIT.
- **WAIT:**
  - While counter ≠ 0: decrement each edge.
  - On the edge where counter = 0:
    - perform the access (array write or read plus extension);
    - register `rsp_rdata` and `rsp_error`;
    - go to RESP.
- **RESP:**
  - `rsp_valid` = 1; `rsp_rdata` and `rsp_error` are held stable.
  - On an edge with `rsp_ready`: go to IDLE and clear `rsp_rdata`/`rsp_error` to 0.
- **Funct3 legality:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 value is illegal → error.
- **Alignment:**
  - Halfword accesses require addr[0] = 0.
  - Word accesses require addr[1:0] = 0.
  - A violation → error.
- **Errored request:**
  - The array is not modified.
  - `rsp_rdata` = 0, `rsp_error` = 1.
  - Latency is unchanged.
- **Addressing:**
  - Word index = addr[DM_ADDRESS-1:2].
  - Byte lane = addr[1:0], little-endian (lane 0 = bits 7:0).
  - SB writes only the selected lane; SH writes lanes {addr[1],0} and {addr[1],1}; other bytes are preserved.
- **Extension:** LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **Array:**
  - Contents are not affected by `reset`.
  - Content after power-up is undefined; the bench preloads with `$readmemh` or writes before reading.

## Timing
- **Reset (`reset` = 0 at an edge):**
  - State → IDLE, counter → 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0.
  - `req_ready` = 0 while `reset` is low and 1 from the first cycle after release.
- **Latency:** a request accepted at edge T0 gives `rsp_valid` = 1 from edge T0+LATENCY. With LATENCY = 1 there is exactly one WAIT cycle.
- **Store visibility:** the store takes effect at edge T0+LATENCY. A later load sees it.
- **Throughput:**
  - `req_ready` returns one cycle after the response handshake edge.
  - Minimum spacing between acceptances is LATENCY+2 cycles.
  - No request is accepted in WAIT or RESP; `req_*` inputs are ignored there.
- **Backpressure:** `rsp_valid` stays high indefinitely while `rsp_ready` = 0, with data unchanged.
- **`rsp_ready` outside RESP** is ignored.
- **Reset mid-operation:**
  - Reset during WAIT discards the pending access; a pending store never modifies the array.
  - Reset during RESP drops the response.
- **Simultaneous reset and `req_valid`:** the request is not accepted.

## Test plan
- **Reset state:** hold `reset` = 0 for 3 cycles with `req_valid` = 1 → `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0 throughout.
- **Word store/load and latency:** LATENCY = 2. SW addr 0x010, data 0xDEADBEEF → `rsp_valid` 2 cycles after acceptance with `rsp_rdata` = 0 and `rsp_error` = 0. Then LW 0x010 → 0xDEADBEEF.
- **Byte lanes and extension:** SB 0x80 to addr 0x013 → LW 0x010 = 0x80ADBEEF, LB 0x013 = 0xFFFFFF80, LBU 0x013 = 0x00000080. Then LH 0x012 = 0xFFFF80AD and LHU 0x012 = 0x000080AD.
- **Misaligned and illegal:**
  - LW 0x011 → `rsp_error` = 1, `rsp_rdata` = 0.
  - SH 0x013 → `rsp_error` = 1; a following LW 0x010 still returns 0x80ADBEEF.
  - Load with funct3 = 011 → `rsp_error` = 1.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles during RESP → `rsp_valid` and `rsp_rdata` stable and `req_ready` = 0. Raise `rsp_ready` → `req_ready` = 1 on the next cycle.
- **Reset mid-WAIT:** SW 0xCAFEF00D to 0x020 over prior content 0x11111111. Pulse `reset` low for one edge while in WAIT → no response is produced. A subsequent LW 0x020 returns 0x11111111.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bus between the MEM stage (master) and the data-memory
//   responder (slave). Both directions use a valid/ready handshake.
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store, 0 = load
//   req_funct3            : RISC-V funct3 of the access
//   req_addr              : byte address
//   req_wdata             : store data (low bytes used for SB/SH)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : extended load data, 0 for stores and errors
//   rsp_error             : misaligned access or illegal funct3
interface dmem_responder_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Far end of the MEM-stage data-memory interface. Owns the data array,
//   models a fixed access latency, applies RV32 byte/halfword/word sizing with
//   little-endian lanes, load sign/zero extension and alignment checking.
//   clock : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : dmem_responder_if slave modport (request and response handshakes)
module dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int LATENCY    = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic                  write_q,  write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0]     wdata_q,  wdata_d;
    logic [DATA_W-1:0]     rdata_q,  rdata_d;
    logic                  error_q,  error_d;

    logic [DATA_W-1:0]     mem [WORDS];
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wword;
    logic [DM_ADDRESS-3:0] word_idx;
    logic [DATA_W-1:0]     cur_word;
    logic                  access_err;

    // Illegal funct3 for the direction, or misaligned halfword/word.
    function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] lane);
        case (f3)
            3'b000:  access_error = 1'b0;
            3'b001:  access_error = lane[0];
            3'b010:  access_error = (lane != 2'b00);
            3'b100:  access_error = wr;
            3'b101:  access_error = wr | lane[0];
            default: access_error = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [DATA_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[7:0];
        for (int i = 0; i < 4; i++) begin
            if (lane == 2'(i)) b = word[8*i +: 8];
        end
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_extend = {{(DATA_W-8){b[7]}}, b};
            3'b001:  load_extend = {{(DATA_W-16){h[15]}}, h};
            3'b100:  load_extend = {{(DATA_W-8){1'b0}}, b};
            3'b101:  load_extend = {{(DATA_W-16){1'b0}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Read-modify-write merge so SB/SH preserve the untouched lanes.
    function automatic logic [DATA_W-1:0] store_merge(input logic [2:0] f3,
                                                      input logic [1:0] lane,
                                                      input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] wd);
        store_merge = old;
        case (f3)
            3'b000: begin
                for (int i = 0; i < 4; i++) begin
                    if (lane == 2'(i)) store_merge[8*i +: 8] = wd[7:0];
                end
            end
            3'b001: begin
                if (lane[1]) store_merge[31:16] = wd[15:0];
                else         store_merge[15:0]  = wd[15:0];
            end
            default: store_merge = wd;
        endcase
    endfunction

    assign word_idx   = addr_q[DM_ADDRESS-1:2];
    assign cur_word   = mem[word_idx];
    assign access_err = access_error(write_q, funct3_q, addr_q[1:0]);

    assign bus.req_ready = (state_q == IDLE) && reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        mem_we    = 1'b0;
        mem_wword = store_merge(funct3_q, addr_q[1:0], cur_word, wdata_q);
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Gating with reset keeps a store aborted by reset out of the array.
                    mem_we  = write_q && !access_err && reset;
                    rdata_d = (write_q || access_err) ? '0
                            : load_extend(funct3_q, addr_q[1:0], cur_word);
                    error_d = access_err;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Latched request fields only matter after acceptance, so they carry no reset.
    always_ff @(posedge clock) begin
        write_q  <= write_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    // Array contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[word_idx] <= mem_wword;
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk;
    logic rst_n;

    dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

    dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(2)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares each new response against the scoreboard head.
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (bus.rsp_valid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected",
                         bus.rsp_rdata, bus.rsp_error);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.name, "_error"}, {31'b0, bus.rsp_error}, {31'b0, e.err});
            end
        end
        if (!bus.rsp_valid) seen = 1'b0;
    end

    // Present a request and wait for acceptance; returns at the negedge after the accept edge.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd);
        bit ok;
        @(negedge clk);
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            $display("FAIL accept_timeout: req_ready stayed 0 for 20 cycles, required 1");
            $fatal(1);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Wait for rsp_valid and check the latency from the accept edge.
    task automatic wait_rsp(input string name);
        int n;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_seen"}, {31'b0, bus.rsp_valid}, 32'd1);
        chk({name, "_latency"}, 32'(n - 1), 32'd2);
    endtask

    task automatic xact(input string name, input logic wr, input logic [2:0] f3,
                        input logic [8:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.name  = name;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q.push_back(e);
        issue(wr, f3, addr, wd);
        wait_rsp(name);
        @(negedge clk);
        chk({name, "_done_ready"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 9'h010;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b1;

        // Reset held with a request present
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
        end
        bus.req_valid = 1'b0;
        rst_n = 1'b1;

        xact("sw_010",  1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0);
        xact("lw_010",  1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        xact("sb_013",  1'b1, 3'b000, 9'h013, 32'h00000080, 32'h0,        1'b0);
        xact("lw_010b", 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0);
        xact("lb_013",  1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFF80, 1'b0);
        xact("lbu_013", 1'b0, 3'b100, 9'h013, 32'h0,        32'h00000080, 1'b0);
        xact("lh_012",  1'b0, 3'b001, 9'h012, 32'h0,        32'hFFFF80AD, 1'b0);
        xact("lhu_012", 1'b0, 3'b101, 9'h012, 32'h0,        32'h000080AD, 1'b0);
        xact("lw_011",  1'b0, 3'b010, 9'h011, 32'h0,        32'h0,        1'b1);
        xact("sh_013",  1'b1, 3'b001, 9'h013, 32'h00001234, 32'h0,        1'b1);
        xact("lw_010c", 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0);
        xact("ld_f011", 1'b0, 3'b011, 9'h010, 32'h0,        32'h0,        1'b1);
        xact("st_f100", 1'b1, 3'b100, 9'h010, 32'h12345678, 32'h0,        1'b1);
        xact("lw_010d", 1'b0, 3'b010, 9'h010, 32'h0,        32'h80ADBEEF, 1'b0);
        xact("sw_014",  1'b1, 3'b010, 9'h014, 32'h01020304, 32'h0,        1'b0);
        xact("sh_016",  1'b1, 3'b001, 9'h016, 32'hAAAA5566, 32'h0,        1'b0);
        xact("sb_014",  1'b1, 3'b000, 9'h014, 32'hFFFFFF99, 32'h0,        1'b0);
        xact("lw_014",  1'b0, 3'b010, 9'h014, 32'h0,        32'h55660399, 1'b0);
        xact("lb_014",  1'b0, 3'b000, 9'h014, 32'h0,        32'hFFFFFF99, 1'b0);
        xact("lh_016",  1'b0, 3'b001, 9'h016, 32'h0,        32'h00005566, 1'b0);

        // Backpressure: response held while rsp_ready is low
        begin
            exp_t e;
            e.name = "bp_lw_010"; e.rdata = 32'h80ADBEEF; e.err = 1'b0;
            exp_q.push_back(e);
        end
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 9'h010, 32'h0);
        wait_rsp("bp_lw_010");
        held = bus.rsp_rdata;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'h80ADBEEF);
            chk("bp_rdata_stable", bus.rsp_rdata, held);
            chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("bp_release_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("bp_release_rdata", bus.rsp_rdata, 32'd0);

        // Reset during WAIT discards a pending store
        xact("sw_020_init", 1'b1, 3'b010, 9'h020, 32'h11111111, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 9'h020, 32'hCAFEF00D);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rstwait_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end
        chk("rstwait_req_ready", {31'b0, bus.req_ready}, 32'd1);
        xact("lw_020", 1'b0, 3'b010, 9'h020, 32'h0, 32'h11111111, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
